// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  // State encoding kept as plain constants so older flows can consume it.
  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StReq  = 2'd0;
  localparam fetch_state_t StWait = 2'd1;
  localparam fetch_state_t StHold = 2'd2;
  localparam fetch_state_t StDrop = 2'd3;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and memory.
interface fetch_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: redirect/advance selection and the sequential +4 adder.
module fetch_pc_reg #(
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [29:0] target_word_i,
  input  logic        advance_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q, pc_d;

  // Redirect wins over sequential advance; targets are always word aligned.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {target_word_i, 2'b00};
    end else if (advance_i) begin
      pc_d = pc_plus4_o;
    end
  end

  // PC state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues one imem request at a time, holds the
// returned instruction for decode and kills in-flight fetches on redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallF,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          PCF,
  output logic [31:0]          PCPlus4F,
  output logic [31:0]          InstrF,
  output logic                 FetchValidF
);

  fetch_state_t state_q, state_d;
  logic [31:0]  buf_q, buf_d;
  logic         advance;

  // Low target bits are architecturally ignored.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^PCTargetE[1:0];

  fetch_pc_reg #(
    .ResetPc (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (PCSrcE),
    .target_word_i (PCTargetE[31:2]),
    .advance_i     (advance),
    .pc_o          (PCF),
    .pc_plus4_o    (PCPlus4F)
  );

  // Next state and buffer capture; a redirect decides whether a response is still owed.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    advance = 1'b0;
    unique case (state_q)
      StReq: begin
        if (imem.imem_req_ready) begin
          state_d = PCSrcE ? StDrop : StWait;
        end
      end
      StWait: begin
        if (PCSrcE) begin
          state_d = imem.imem_rsp_valid ? StReq : StDrop;
        end else if (imem.imem_rsp_valid) begin
          buf_d   = imem.imem_rsp_data;
          state_d = StHold;
        end
      end
      StHold: begin
        if (PCSrcE) begin
          state_d = StReq;
        end else if (!StallF) begin
          advance = 1'b1;
          state_d = StReq;
        end
      end
      StDrop: begin
        if (imem.imem_rsp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // FSM state and instruction buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReq;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs depend on state only.
  always_comb begin
    imem.imem_req_valid = (state_q == StReq);
    imem.imem_addr      = PCF;
    FetchValidF         = (state_q == StHold);
    InstrF              = (state_q == StHold) ? buf_q : NOP_INSTR;
  end

endmodule
